uart_io_bridge: RTL



---
 rtl/uart_io_bridge.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_io_bridge.sv
// Board I/O bridge: registered switch->LED path plus a FIFO-buffered, baud-timed UART transmitter.
// Define UART_IO_PARITY_EN to append an even-parity bit between the data bits and the stop bit.
module uart_io_bridge #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int IO_WIDTH     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [IO_WIDTH-1:0]           switches,
   output logic [IO_WIDTH-1:0]           leds,
   input  logic                          tx_valid,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx_ready,
   output logic                          uart_tx,
   output logic                          uart_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

`ifdef UART_IO_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                state, state_nx;
   logic [BAUD_W-1:0]     baud_cnt, baud_nx;
   logic [BIT_W-1:0]      bit_cnt, bit_nx;
   logic                  tx_nx, busy_nx;
   logic                  pop, push, shift_en, baud_done;
   logic [DATA_BITS-1:0]  shift_q;
   logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0]  head;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [LVL_W-1:0]      level, level_nx;
`ifdef UART_IO_PARITY_EN
   logic                  parity_q;
`endif

   // tx_ready depends only on the registered level, never on tx_valid
   assign tx_ready   = (level < LVL_FULL);
   assign push       = tx_valid && tx_ready;
   assign head       = mem[rd_ptr];
   assign fifo_level = level;
   assign baud_done  = (baud_cnt == BAUD_LAST);

   always_comb begin
      level_nx = level;
      case ({push, pop})
         2'b10:   level_nx = level + LVL_W'(1);
         2'b01:   level_nx = level - LVL_W'(1);
         default: level_nx = level;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds <= '0;
      end else begin
         leds <= switches;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_nx;
      end
   end

   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_cnt;
      tx_nx    = uart_tx;
      pop      = 1'b0;
      shift_en = 1'b0;
      case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (level != '0) begin
               pop      = 1'b1;
               state_nx = START;
               baud_nx  = '0;
               bit_nx   = '0;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (baud_done) begin
               state_nx = DATA;
               baud_nx  = '0;
               tx_nx    = shift_q[0];
            end else begin
               baud_nx = baud_cnt + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_nx = '0;
               if (bit_cnt == BIT_LAST) begin
`ifdef UART_IO_PARITY_EN
                  state_nx = PARITY;
                  tx_nx    = parity_q;
`else
                  state_nx = STOP;
                  tx_nx    = 1'b1;
`endif
               end else begin
                  bit_nx   = bit_cnt + BIT_W'(1);
                  shift_en = 1'b1;
                  tx_nx    = shift_q[1];
               end
            end else begin
               baud_nx = baud_cnt + BAUD_W'(1);
            end
         end
`ifdef UART_IO_PARITY_EN
         PARITY: begin
            if (baud_done) begin
               state_nx = STOP;
               baud_nx  = '0;
               tx_nx    = 1'b1;
            end else begin
               baud_nx = baud_cnt + BAUD_W'(1);
            end
         end
`endif
         STOP: begin
            if (baud_done) begin
               state_nx = IDLE;
               baud_nx  = '0;
               tx_nx    = 1'b1;
            end else begin
               baud_nx = baud_cnt + BAUD_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
         end
      endcase
      // busy is registered from next-state values so it never glitches
      busy_nx = (state_nx != IDLE) || (level_nx != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         uart_tx   <= 1'b1;
         uart_busy <= 1'b0;
      end else begin
         state     <= state_nx;
         baud_cnt  <= baud_nx;
         bit_cnt   <= bit_nx;
         uart_tx   <= tx_nx;
         uart_busy <= busy_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         shift_q <= head;
      end else if (shift_en) begin
         shift_q <= shift_q >> 1;
      end
   end

`ifdef UART_IO_PARITY_EN
   always_ff @(posedge clk) begin
      if (pop) begin
         parity_q <= ^head;
      end
   end
`endif

endmodule
